// File: rtl/tg_pkg.sv
// Shared constants and helpers for the traffic-generator app-side blocks.
// Latency: none (constants and elaboration-time functions only).
// Backpressure: not applicable.
package tg_pkg;

  // Command encoding that carries write data; every other encoding is a non-write.
  localparam logic [2:0] TG_CMD_WRITE = 3'b000;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tg_sync_fifo.sv
// Synchronous first-word-fall-through FIFO of DEPTH entries, WIDTH bits each.
// Latency: a push into an empty FIFO appears on head_dat_o one cycle later.
// Backpressure: the caller never pushes when full nor pops when empty; count_o reports occupancy.
module tg_sync_fifo
  import tg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_dat_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_dat_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Storage is left unreset: only the pointers and count say which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/tg_app_buffer.sv
// Decoupling buffer between the traffic-generator arbiter and the memory-controller app port.
// Latency: one cycle from a push into an empty FIFO to its presentation on app_*.
// Backpressure: up_rdy/up_wdf_rdy drop only when full; a write command waits until its data has gone out.
module tg_app_buffer
  import tg_pkg::*;
#(
  // Clock-to-output delay (ps) carried for compatibility with existing instantiations.
  parameter int TCQ            = 100,
  parameter int APP_DATA_WIDTH = 32,
  parameter int APP_ADDR_WIDTH = 32,
  parameter int APP_CMD_WIDTH  = 3,
  parameter int DEPTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        up_en,
  input  logic [APP_CMD_WIDTH-1:0]    up_cmd,
  input  logic [APP_ADDR_WIDTH-1:0]   up_addr,
  output logic                        up_rdy,
  input  logic                        up_wdf_wren,
  input  logic [APP_DATA_WIDTH-1:0]   up_wdf_data,
  input  logic [APP_DATA_WIDTH/8-1:0] up_wdf_mask,
  input  logic                        up_wdf_end,
  output logic                        up_wdf_rdy,
  output logic                        app_en,
  output logic [APP_CMD_WIDTH-1:0]    app_cmd,
  output logic [APP_ADDR_WIDTH-1:0]   app_addr,
  input  logic                        app_rdy,
  output logic                        app_wdf_wren,
  output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                        app_wdf_end,
  input  logic                        app_wdf_rdy,
  output logic [clog2(DEPTH):0]       cmd_count,
  output logic [clog2(DEPTH):0]       wdf_count,
  output logic                        wr_bal_err
);

  localparam int CNT_W  = clog2(DEPTH) + 1;
  localparam int BAL_W  = clog2(DEPTH) + 3;
  localparam int MASK_W = APP_DATA_WIDTH / 8;
  localparam int CMD_FW = APP_CMD_WIDTH + APP_ADDR_WIDTH;
  localparam int WDF_FW = APP_DATA_WIDTH + MASK_W + 1;
  localparam logic [BAL_W-1:0] BAL_MAX = '1;

  logic              cmd_push, cmd_pop, wdf_push, wdf_pop;
  logic [CMD_FW-1:0] cmd_head;
  logic [WDF_FW-1:0] wdf_head;
  logic              head_is_wr, end_pop, wr_cmd_pop;
  logic [BAL_W-1:0]  wr_bal_q, wr_bal_d;
  logic              wr_bal_err_q, wr_bal_err_d;

  // Ready depends only on occupancy, never on the upstream enables.
  assign up_rdy     = (cmd_count != CNT_W'(DEPTH));
  assign up_wdf_rdy = (wdf_count != CNT_W'(DEPTH));
  assign cmd_push   = up_en & up_rdy & ~rst;
  assign wdf_push   = up_wdf_wren & up_wdf_rdy & ~rst;

  tg_sync_fifo #(.WIDTH(CMD_FW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (cmd_push),
    .push_dat_i ({up_cmd, up_addr}),
    .pop_i      (cmd_pop),
    .head_dat_o (cmd_head),
    .count_o    (cmd_count)
  );

  tg_sync_fifo #(.WIDTH(WDF_FW), .DEPTH(DEPTH)) u_wdf_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (wdf_push),
    .push_dat_i ({up_wdf_data, up_wdf_mask, up_wdf_end}),
    .pop_i      (wdf_pop),
    .head_dat_o (wdf_head),
    .count_o    (wdf_count)
  );

  assign {app_cmd, app_addr}                      = cmd_head;
  assign {app_wdf_data, app_wdf_mask, app_wdf_end} = wdf_head;

  // Data side runs freely; the command side holds a write until a completed burst covers it,
  // either already counted in wr_bal or finishing in this very cycle.
  assign app_wdf_wren = (wdf_count != '0);
  assign wdf_pop      = app_wdf_wren & app_wdf_rdy;
  assign end_pop      = wdf_pop & app_wdf_end;
  assign head_is_wr   = (app_cmd == APP_CMD_WIDTH'(TG_CMD_WRITE));
  assign app_en       = (cmd_count != '0) & (~head_is_wr | (wr_bal_q != '0) | end_pop);
  assign cmd_pop      = app_en & app_rdy;
  assign wr_cmd_pop   = cmd_pop & head_is_wr;

  // Write balance: completed bursts minus issued write commands, saturating with a sticky error.
  always_comb begin
    wr_bal_d     = wr_bal_q;
    wr_bal_err_d = wr_bal_err_q;
    case ({end_pop, wr_cmd_pop})
      2'b10: begin
        if (wr_bal_q == BAL_MAX) wr_bal_err_d = 1'b1;
        else                     wr_bal_d     = wr_bal_q + BAL_W'(1);
      end
      2'b01:   wr_bal_d = wr_bal_q - BAL_W'(1);
      default: wr_bal_d = wr_bal_q;
    endcase
  end

  // Balance and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bal_q     <= '0;
      wr_bal_err_q <= 1'b0;
    end else begin
      wr_bal_q     <= wr_bal_d;
      wr_bal_err_q <= wr_bal_err_d;
    end
  end

  assign wr_bal_err = wr_bal_err_q;

endmodule

// File: tb/tb_tg_app_buffer.sv
// Randomized scoreboard bench for tg_app_buffer with an occupancy/balance reference model.
// Latency: checks run every cycle on the falling edge against the model state.
// Backpressure: app_rdy/app_wdf_rdy are driven randomly and in directed patterns.
module tb_tg_app_buffer;
  import tg_pkg::*;

  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int CW        = 3;
  localparam int DEPTH     = 4;
  localparam int MW        = DW / 8;
  localparam int NW        = clog2(DEPTH) + 1;
  localparam int BAL_LIMIT = (1 << (clog2(DEPTH) + 3)) - 1;

  typedef struct packed { logic [CW-1:0] cmd; logic [AW-1:0] addr; } cmd_t;
  typedef struct packed { logic [DW-1:0] data; logic [MW-1:0] mask; logic last; } beat_t;

  logic          clk, rst;
  logic          up_en, up_rdy, up_wdf_wren, up_wdf_end, up_wdf_rdy;
  logic [CW-1:0] up_cmd, app_cmd;
  logic [AW-1:0] up_addr, app_addr;
  logic [DW-1:0] up_wdf_data, app_wdf_data;
  logic [MW-1:0] up_wdf_mask, app_wdf_mask;
  logic          app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [NW-1:0] cmd_count, wdf_count;
  logic          wr_bal_err;

  tg_app_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .up_en(up_en), .up_cmd(up_cmd), .up_addr(up_addr), .up_rdy(up_rdy),
    .up_wdf_wren(up_wdf_wren), .up_wdf_data(up_wdf_data), .up_wdf_mask(up_wdf_mask),
    .up_wdf_end(up_wdf_end), .up_wdf_rdy(up_wdf_rdy),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .cmd_count(cmd_count), .wdf_count(wdf_count), .wr_bal_err(wr_bal_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what has been accepted but not yet delivered, plus burst/command totals.
  cmd_t  cmd_q[$];
  beat_t wdf_q[$];
  int    ends_popped, wrs_popped, wr_acc, end_acc;
  bit    err_exp;
  int    cmd_pop_now, wdf_pop_now;
  int    n_tests, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: compares DUT outputs to the model, then retires what the DUT hands out.
  always @(negedge clk) begin
    bit end_now, en_exp;
    cmd_pop_now = 0;
    wdf_pop_now = 0;
    if (rst) begin
      cmd_q.delete();
      wdf_q.delete();
      ends_popped = 0; wrs_popped = 0; wr_acc = 0; end_acc = 0;
      err_exp = 1'b0;
    end else begin
      check("cmd_count", 64'(cmd_count), 64'(cmd_q.size()));
      check("wdf_count", 64'(wdf_count), 64'(wdf_q.size()));
      check("up_rdy", 64'(up_rdy), 64'(cmd_q.size() != DEPTH));
      check("up_wdf_rdy", 64'(up_wdf_rdy), 64'(wdf_q.size() != DEPTH));
      check("app_wdf_wren", 64'(app_wdf_wren), 64'(wdf_q.size() != 0));
      check("wr_bal_err", 64'(wr_bal_err), 64'(err_exp));
      end_now = (wdf_q.size() != 0) && app_wdf_rdy && wdf_q[0].last;
      en_exp  = (cmd_q.size() != 0) &&
                ((cmd_q[0].cmd != TG_CMD_WRITE) || (ends_popped > wrs_popped) || end_now);
      check("app_en", 64'(app_en), 64'(en_exp));
      if (app_en && app_rdy && cmd_q.size() != 0) begin
        check("app_cmd", 64'(app_cmd), 64'(cmd_q[0].cmd));
        check("app_addr", 64'(app_addr), 64'(cmd_q[0].addr));
        if (cmd_q[0].cmd == TG_CMD_WRITE) wrs_popped++;
        void'(cmd_q.pop_front());
        cmd_pop_now = 1;
      end
      if (app_wdf_wren && app_wdf_rdy && wdf_q.size() != 0) begin
        check("app_wdf_data", 64'(app_wdf_data), 64'(wdf_q[0].data));
        check("app_wdf_mask", 64'(app_wdf_mask), 64'(wdf_q[0].mask));
        check("app_wdf_end", 64'(app_wdf_end), 64'(wdf_q[0].last));
        if (wdf_q[0].last) ends_popped++;
        void'(wdf_q.pop_front());
        wdf_pop_now = 1;
      end
      if (ends_popped - wrs_popped > BAL_LIMIT) err_exp = 1'b1;
    end
  end

  // Input recorder: pushes the expected response for every handshake the spec says is accepted.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (up_en && (cmd_q.size() + cmd_pop_now != DEPTH)) begin
        cmd_q.push_back({up_cmd, up_addr});
        if (up_cmd == TG_CMD_WRITE) wr_acc++;
      end
      if (up_wdf_wren && (wdf_q.size() + wdf_pop_now != DEPTH)) begin
        wdf_q.push_back({up_wdf_data, up_wdf_mask, up_wdf_end});
        if (up_wdf_end) end_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [CW-1:0] c, input logic [AW-1:0] a);
    int guard;
    guard = 0;
    up_en = 1'b1; up_cmd = c; up_addr = a;
    while (!up_rdy && guard < 50) begin step(); guard++; end
    if (!up_rdy) begin
      n_tests++; n_fail++;
      $display("FAIL send_cmd_timeout: up_rdy=%0b, required 1", up_rdy);
    end
    step();
    up_en = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic l);
    int guard;
    guard = 0;
    up_wdf_wren = 1'b1; up_wdf_data = d; up_wdf_mask = m; up_wdf_end = l;
    while (!up_wdf_rdy && guard < 50) begin step(); guard++; end
    if (!up_wdf_rdy) begin
      n_tests++; n_fail++;
      $display("FAIL send_beat_timeout: up_wdf_rdy=%0b, required 1", up_wdf_rdy);
    end
    step();
    up_wdf_wren = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    up_en = 1'b0; up_cmd = '0; up_addr = '0;
    up_wdf_wren = 1'b0; up_wdf_data = '0; up_wdf_mask = '0; up_wdf_end = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // Single read goes straight through.
    send_cmd(3'b001, 32'h40);
    step(); step();

    // Write command waits three cycles for its data; both leave together.
    send_cmd(TG_CMD_WRITE, 32'h80);
    step(); step(); step();
    send_beat(32'hA5A5A5A5, 4'hF, 1'b1);
    step(); step();

    // Fill the command FIFO with the controller stalled, try one extra push, then drain.
    app_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(3'b010, 32'h200 + 32'(i * 16));
    check("full_up_rdy", 64'(up_rdy), 64'd0);
    up_en = 1'b1; up_cmd = 3'b011; up_addr = 32'h2FF;
    step(); step();
    up_en = 1'b0;
    app_rdy = 1'b1;
    repeat (6) step();

    // Ten reads against a controller that is ready every other cycle.
    fork
      begin
        for (int i = 0; i < 10; i++) send_cmd(3'($urandom_range(1, 7)), 32'h1000 + 32'(i * 4));
      end
      begin
        repeat (40) begin app_rdy = ~app_rdy; step(); end
      end
    join
    app_rdy = 1'b1;
    repeat (6) step();

    // Reset with entries buffered: everything is discarded and upstream is ignored during rst.
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send_cmd(3'b001, 32'h300 + 32'(i));
    send_beat(32'h11111111, 4'h3, 1'b0);
    send_beat(32'h22222222, 4'hC, 1'b1);
    rst = 1'b1; up_en = 1'b1; up_cmd = 3'b001; up_addr = 32'h3FF;
    step();
    rst = 1'b0; up_en = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    check("post_rst_cmd_count", 64'(cmd_count), 64'd0);
    check("post_rst_app_en", 64'(app_en), 64'd0);
    step(); step();

    // Random mixed traffic with bounded data lead over commands.
    for (int cyc = 0; cyc < 600; cyc++) begin
      up_en       = 1'($urandom_range(0, 1));
      up_cmd      = ($urandom_range(0, 1) != 0) ? TG_CMD_WRITE : 3'($urandom_range(1, 7));
      up_addr     = $urandom;
      up_wdf_wren = (wr_acc > end_acc) ? ($urandom_range(0, 3) != 0)
                                       : ((end_acc - wr_acc < 6) && ($urandom_range(0, 3) == 0));
      up_wdf_data = $urandom;
      up_wdf_mask = 4'($urandom);
      up_wdf_end  = 1'($urandom_range(0, 1));
      app_rdy     = ($urandom_range(0, 3) != 0);
      app_wdf_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    up_en = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int g = 0; g < 300; g++) begin
      if (cmd_q.size() == 0 && wdf_q.size() == 0 && wr_acc <= end_acc) break;
      up_wdf_wren = (wr_acc > end_acc);
      up_wdf_data = $urandom; up_wdf_mask = 4'($urandom); up_wdf_end = 1'b1;
      step();
    end
    up_wdf_wren = 1'b0;
    step();
    check("drain_cmd_count", 64'(cmd_count), 64'd0);
    check("drain_wdf_count", 64'(wdf_count), 64'd0);

    // Data-only traffic until the write balance saturates; the error flag is sticky.
    pulse_rst();
    for (int i = 0; i < 40; i++) send_beat($urandom, 4'hF, 1'b1);
    repeat (3) step();
    check("sat_err_set", 64'(wr_bal_err), 64'd1);
    repeat (5) step();
    check("sat_err_sticky", 64'(wr_bal_err), 64'd1);
    pulse_rst();
    check("sat_err_cleared", 64'(wr_bal_err), 64'd0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
